// File: rtl/audio_tick_gen.sv
// audio_tick_gen: per-channel fractional-N clock-enable tick generator.
// Ports: IO_main_clk, IO_rst (sync, active high), IO_en[CHANNELS] run enables,
//   IO_wr_en/IO_wr_ch/IO_wr_int/IO_wr_frac shadow-divisor write port,
//   IO_sync phase restart (only with macro TICK_SYNC_EN),
//   IO_tick[CHANNELS] one-cycle pulses, IO_pending[CHANNELS] shadow-awaiting-commit.
module audio_tick_gen #(
  parameter int CHANNELS     = 2,
  parameter int INT_W        = 12,
  parameter int FRAC_W       = 8,
  parameter int DEFAULT_INT  = 1507,
  parameter int DEFAULT_FRAC = 0
) (
  input  logic                IO_main_clk,
  input  logic                IO_rst,
  input  logic [CHANNELS-1:0] IO_en,
  input  logic                IO_wr_en,
  input  logic [2:0]          IO_wr_ch,
  input  logic [INT_W-1:0]    IO_wr_int,
  input  logic [FRAC_W-1:0]   IO_wr_frac,
`ifdef TICK_SYNC_EN
  input  logic                IO_sync,
`endif
  output logic [CHANNELS-1:0] IO_tick,
  output logic [CHANNELS-1:0] IO_pending
);

  localparam logic [INT_W-1:0]  DEF_N = INT_W'(DEFAULT_INT);
  localparam logic [FRAC_W-1:0] DEF_F = FRAC_W'(DEFAULT_FRAC);
  localparam logic [INT_W:0]    ONE   = (INT_W+1)'(1);
  localparam logic [INT_W:0]    ZERO  = '0;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [INT_W:0]    cnt_q, cnt_d;
    logic [FRAC_W-1:0] acc_q, acc_d;
    logic              ext_q, ext_d;
    logic              run_q, run_d;
    logic              tick_q, tick_d;
    logic              pend_q, pend_d;
    logic [INT_W-1:0]  an_q, an_d, sn_q, sn_d;
    logic [FRAC_W-1:0] af_q, af_d, sf_q, sf_d;
    logic [FRAC_W:0]   sum;
    logic              wr_hit, wrap, commit;

    always_comb begin
      wr_hit = IO_wr_en && (IO_wr_ch == 3'(g));
      // run_q marks that the counter has already spent its first
      // enabled cycle at zero, so re-enable gives a full period.
      wrap   = run_q &&
               (cnt_q == ({1'b0, an_q} + {{INT_W{1'b0}}, ext_q}));
      commit = pend_q && (wrap || !IO_en[g]);
`ifdef TICK_SYNC_EN
      if (IO_sync) commit = pend_q;
`endif
      an_d = commit ? sn_q : an_q;
      af_d = commit ? sf_q : af_q;
      sum  = {1'b0, acc_q} + {1'b0, af_d};

      cnt_d = cnt_q;
      acc_d = acc_q;
      ext_d = ext_q;
      run_d = run_q;
      if (!IO_en[g]) begin
        cnt_d = ZERO;
        acc_d = '0;
        ext_d = 1'b0;
        run_d = 1'b0;
      end else if (!run_q) begin
        cnt_d = ZERO;
        run_d = 1'b1;
      end else if (wrap) begin
        // new divisor's fraction decides the next period's stretch
        cnt_d = ZERO;
        acc_d = sum[FRAC_W-1:0];
        ext_d = sum[FRAC_W];
      end else begin
        cnt_d = cnt_q + ONE;
      end
      tick_d = run_d &&
               (cnt_d == ({1'b0, an_d} + {{INT_W{1'b0}}, ext_d}));
`ifdef TICK_SYNC_EN
      if (IO_sync) begin
        cnt_d  = ZERO;
        acc_d  = '0;
        ext_d  = 1'b0;
        run_d  = IO_en[g];
        tick_d = 1'b0;
      end
`endif

      sn_d   = sn_q;
      sf_d   = sf_q;
      pend_d = pend_q && !commit;
      if (wr_hit) begin
        sn_d   = IO_wr_int;
        sf_d   = IO_wr_frac;
        pend_d = 1'b1;
      end
    end

    always_ff @(posedge IO_main_clk) begin
      if (IO_rst) begin
        cnt_q  <= ZERO;
        acc_q  <= '0;
        ext_q  <= 1'b0;
        run_q  <= 1'b0;
        tick_q <= 1'b0;
        pend_q <= 1'b0;
        an_q   <= DEF_N;
        af_q   <= DEF_F;
        sn_q   <= DEF_N;
        sf_q   <= DEF_F;
      end else begin
        cnt_q  <= cnt_d;
        acc_q  <= acc_d;
        ext_q  <= ext_d;
        run_q  <= run_d;
        tick_q <= tick_d;
        pend_q <= pend_d;
        an_q   <= an_d;
        af_q   <= af_d;
        sn_q   <= sn_d;
        sf_q   <= sf_d;
      end
    end

    assign IO_tick[g]    = tick_q;
    assign IO_pending[g] = pend_q;
  end

endmodule

// File: doc/audio_tick_gen.md
AUDIO_TICK_GEN -- requirements
Module: audio_tick_gen

Interface
REQ-001 Parameter CHANNELS, default 2, number of independent tick channels (1..8).
REQ-002 Parameter INT_W, default 12, width of the integer divisor field.
REQ-003 Parameter FRAC_W, default 8, width of the fractional divisor field.
REQ-004 Parameter DEFAULT_INT, default 1507, integer divisor loaded at reset (1508-cycle period, the current audio rate).
REQ-005 Parameter DEFAULT_FRAC, default 0, fractional divisor loaded at reset.
REQ-006 IO_main_clk  in  1  sole clock; all logic on its rising edge.
REQ-007 IO_rst  in  1  synchronous, active-high reset.
REQ-008 IO_en  in  CHANNELS  per-channel run enable.
REQ-009 IO_wr_en  in  1  divisor write strobe, one cycle.
REQ-010 IO_wr_ch  in  3  target channel of the write.
REQ-011 IO_wr_int  in  INT_W  integer divisor value N.
REQ-012 IO_wr_frac  in  FRAC_W  fractional divisor value F.
REQ-013 IO_sync  in  1  phase-restart strobe (present only with TICK_SYNC_EN).
REQ-014 IO_tick  out  CHANNELS  registered one-cycle clock-enable pulse per channel.
REQ-015 IO_pending  out  CHANNELS  registered; high while a written divisor awaits commit.

Function
REQ-016 Each channel SHALL hold an active divisor {N,F}, a shadow divisor, a counter (INT_W+1 bits) and a FRAC_W-bit phase accumulator.
REQ-017 With IO_en high, the counter SHALL increment each cycle and wrap at period P = N+1, or N+2 when the current period is extended.
REQ-018 IO_tick SHALL be high for exactly the one cycle in which the counter holds its last value P-1; never two consecutive cycles unless P = 1.
REQ-019 At each wrap the accumulator SHALL add F modulo 2^FRAC_W; a carry out SHALL extend the next period by one cycle, giving average period N+1+F/2^FRAC_W.
REQ-020 N = 0, F = 0 SHALL tick every cycle; N = 2^INT_W-1 SHALL not overflow the counter.
REQ-021 IO_wr_en with IO_wr_ch < CHANNELS SHALL load the shadow and set IO_pending next cycle; IO_wr_ch >= CHANNELS SHALL be ignored.
REQ-022 A pending shadow SHALL commit to active on the tick cycle, clearing IO_pending the following cycle; the period just ended uses the old divisor.
REQ-023 A write coinciding with a commit SHALL commit the previous shadow, capture the new value, and keep IO_pending high.
REQ-024 A write to a disabled channel SHALL commit on the next cycle without waiting for a tick.
REQ-025 IO_en low SHALL hold counter and accumulator at zero and force IO_tick low; on re-enable the first tick SHALL come P cycles later.
REQ-026 Channels SHALL be fully independent; no arbitration between channels.

Reset
REQ-027 IO_rst high SHALL set all counters and accumulators to 0, active and shadow divisors to {DEFAULT_INT, DEFAULT_FRAC}, IO_tick and IO_pending to 0.
REQ-028 Reset SHALL override IO_wr_en and IO_sync in the same cycle; a pending write is discarded.
REQ-029 After reset release with IO_en high, the first tick SHALL occur in the DEFAULT_INT+1-th cycle.

Configuration
REQ-030 Macro TICK_SYNC_EN defined: IO_sync high SHALL, next cycle, zero every counter and accumulator, commit all pending shadows, and suppress IO_tick in the sync cycle; write in the same cycle lands in the shadow, pending set.
REQ-031 Macro TICK_SYNC_EN undefined: IO_sync port and its logic SHALL be absent; all other behaviour unchanged.

Verification
REQ-032 Reset, IO_en=2'b11, defaults -> ticks on both channels every 1508 cycles, first at cycle 1508.
REQ-033 Write ch0 N=9 F=128 -> IO_pending[0] until next tick; thereafter periods alternate 10,11 (average 10.5 over 256 ticks, exactly 2688 cycles).
REQ-034 Write ch1 N=0 F=0 -> IO_tick[1] continuously high after commit; ch0 unaffected.
REQ-035 Write in the tick cycle of ch0 (N=4 then N=7) -> old value's successor N=4 active for one period, IO_pending stays high, N=7 commits at next tick.
REQ-036 IO_en[0] dropped mid-period, write N=3, re-raised -> commit next cycle, first tick 4 cycles after re-enable.
REQ-037 With TICK_SYNC_EN: channels at arbitrary phases, pulse IO_sync -> no tick that cycle, both channels tick together P cycles later when divisors equal.
